// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state encoding and the
// slave-select index width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        HOLD = 2'd2
    } state_t;

    // A single slave still gets a 1-bit select port.
    function automatic int ss_width(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: free-running counter while run is high, preset to HALF
// otherwise. Emits the MISO sample strobe and the shift strobe.
module spi_sclk_gen #(
    parameter int DIV_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk,
    output logic smpl_tick,
    output logic shft_tick
);

    localparam logic [DIV_W-1:0] HALF    = {1'b1, {(DIV_W-1){1'b0}}};
    localparam logic [DIV_W-1:0] HALF_M1 = {1'b0, {(DIV_W-1){1'b1}}};

    logic [DIV_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= HALF;
        end else if (!run) begin
            cnt <= HALF;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Presetting to HALF gives a full high half-period before the first fall.
    assign sclk      = run ? cnt[DIV_W-1] : 1'b1;
    assign smpl_tick = run && (cnt == HALF_M1);
    assign shft_tick = run && (&cnt);

endmodule

// File: rtl/spi_mstr_param.sv
// Parametrised mode-3 SPI master: full-duplex DATA_W-bit transfers with
// selectable bit order, multiple slave selects and an SS_n back porch.
module spi_mstr_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DIV_W     = 5,
    parameter int NUM_SS    = 1,
    parameter int LSB_FIRST = 0,
    parameter int SS_HOLD   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wrt,
    input  logic [DATA_W-1:0]             cmd,
    input  logic [ss_width(NUM_SS)-1:0]   ss_sel,
    input  logic                          MISO,
    output logic                          MOSI,
    output logic                          SCLK,
    output logic [NUM_SS-1:0]             SS_n,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             rd_data
);

    localparam int BIT_W  = $clog2(DATA_W) + 1;
    localparam int HOLD_W = (SS_HOLD > 1) ? $clog2(SS_HOLD) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'((SS_HOLD > 0) ? SS_HOLD - 1 : 0);

    state_t              state;
    logic [DATA_W-1:0]   shft_reg;
    logic                smpl;
    logic                smpl_seen;
    logic [BIT_W-1:0]    bit_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NUM_SS-1:0]   ss_dec_n;
    logic                smpl_tick;
    logic                shft_tick;

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state == XFER),
        .sclk      (SCLK),
        .smpl_tick (smpl_tick),
        .shft_tick (shft_tick)
    );

    // Out-of-range indices decode to no select; the transfer still runs.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        ss_dec_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (int'(ss_sel) == i) ss_dec_n[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shft_reg  <= '0;
            smpl      <= 1'b0;
            smpl_seen <= 1'b0;
            bit_cnt   <= '0;
            hold_cnt  <= '0;
            SS_n      <= '1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrt) begin
                        shft_reg  <= cmd;
                        smpl_seen <= 1'b0;
                        bit_cnt   <= '0;
                        SS_n      <= ss_dec_n;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (smpl_tick) begin
                        smpl      <= MISO;
                        smpl_seen <= 1'b1;
                    end
                    // The all-ones tick inside the front porch has no sample yet.
                    if (shft_tick && smpl_seen) begin
                        shft_reg <= (LSB_FIRST != 0) ? {smpl, shft_reg[DATA_W-1:1]}
                                                     : {shft_reg[DATA_W-2:0], smpl};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            if (SS_HOLD == 0) begin
                                SS_n  <= '1;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                hold_cnt <= '0;
                                state    <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == LAST_HOLD) begin
                        SS_n  <= '1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MOSI    = (LSB_FIRST != 0) ? shft_reg[0] : shft_reg[DATA_W-1];
    assign rd_data = shft_reg;

endmodule
